usr_rotate_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its `sel`/`M` inputs. It accepts one command per valid/ready handshake: parallel load, load then rotate N places right or left, or read-back. It replays the required `sel`/`M` sequence one step per clock, then returns the final register contents with a `done` pulse. The register's `Q` is fed back, and every result is checked against an internal shadow copy.

---
 rtl/usr_rotate_ctrl_if.sv | 27 ++
 rtl/usr_rotate_ctrl.sv | 129 ++++++++++++
 tb/tb_usr_rotate_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/usr_rotate_ctrl_if.sv
// Command and register-side signal bundle for the rotate sequencer.
// The slave modport is the sequencer's view; the master modport drives commands and Q.
interface usr_rotate_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       Q;
  logic [1:0]       sel;
  logic [3:0]       M;
  logic [3:0]       result;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, Q,
    input  cmd_ready, sel, M, result, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, Q,
    output cmd_ready, sel, M, result, done, err
  );
endinterface

// File: rtl/usr_rotate_ctrl.sv
// Sequencer that replays load/rotate/read steps onto a 4-bit universal shift register
// and checks the fed-back Q against a shadow copy of the expected contents.
module usr_rotate_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input logic              clk,
  input logic              clr,
  usr_rotate_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StRot, StRead, StDone} state_e;
  typedef enum logic [1:0] {OpLoad = 2'b00, OpRotR = 2'b01, OpRotL = 2'b10, OpRead = 2'b11} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       m_q, m_d;
  logic [3:0]       result_q, result_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  function automatic logic [3:0] rot(input logic [3:0] v, input op_e op);
    return (op == OpRotR) ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid && ready_q) begin
          op_d    = op_e'(bus.cmd_op);
          data_d  = bus.cmd_data;
          cnt_d   = bus.cmd_cnt;
          state_d = (op_e'(bus.cmd_op) == OpRead) ? StRead : StLoad;
        end
      end
      StLoad: begin
        shadow_d = data_q;
        if (op_q != OpLoad && cnt_q != '0) begin
          state_d = StRot;
        end else begin
          state_d  = StDone;
          result_d = bus.Q;
          err_d    = (bus.Q != data_q);
        end
      end
      StRot: begin
        shadow_d = rot(shadow_q, op_q);
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = StDone;
          result_d = bus.Q;
          err_d    = (bus.Q != shadow_d);
        end
      end
      StRead: begin
        shadow_d = bus.Q;
        state_d  = StDone;
        result_d = bus.Q;
        err_d    = 1'b0;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they leave the flops already settled.
    sel_d   = 2'b00;
    m_d     = shadow_d;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      StIdle: ready_d = 1'b1;
      StLoad: begin
        sel_d = 2'b11;
        m_d   = data_d;
      end
      StRot:   sel_d = (op_d == OpRotR) ? 2'b01 : 2'b10;
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      op_q     <= OpLoad;
      data_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      m_q      <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      m_q      <= m_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.sel       = sel_q;
  assign bus.M         = m_q;
  assign bus.result    = result_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_usr_rotate_ctrl.sv
// Randomized bench for usr_rotate_ctrl with a falling-edge register model and a
// rotate-by-arithmetic reference for results, latency and fault flags.
module tb_usr_rotate_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  usr_rotate_ctrl_if #(.CNT_W(4)) bus ();

  usr_rotate_ctrl #(.CNT_W(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream register: samples sel/M on the falling edge; mask models stuck-at-0 bits.
  logic [3:0] reg_q;
  logic [3:0] mask = 4'hF;
  always @(negedge clk) begin
    if (clr) reg_q <= 4'h0;
    else begin
      case (bus.sel)
        2'b01:   reg_q <= {bus.M[0], bus.M[3:1]};
        2'b10:   reg_q <= {bus.M[2:0], bus.M[3]};
        2'b11:   reg_q <= bus.M;
        default: ;
      endcase
    end
  end
  assign bus.Q = reg_q & mask;

  // Reference: true contents of the register after each command.
  int ref_val = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rotate_ref(input int op, input int data, input int cnt);
    int k;
    k = cnt % 4;
    if (op == 1) return ((data >> k) | (data << (4 - k))) & 15;
    if (op == 2) return ((data << k) | (data >> (4 - k))) & 15;
    return data;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command in the current (IDLE) cycle and follows it to completion.
  task automatic run_cmd(input int op, input int data, input int cnt, input bit busy_poke);
    int lat, got_cyc, exp_res, exp_err, true_val, mcnt;
    mcnt = (op == 1 || op == 2) ? cnt : 0;
    lat  = (op == 3) ? 2 : mcnt + 2;
    if (op == 3) begin
      exp_res = ref_val & int'(mask);
      exp_err = 0;
      true_val = ref_val;
    end else begin
      true_val = rotate_ref(op, data, mcnt);
      exp_res  = true_val & int'(mask);
      exp_err  = (exp_res != true_val) ? 1 : 0;
    end
    check("ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op[1:0];
    bus.cmd_data  = data[3:0];
    bus.cmd_cnt   = cnt[3:0];
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 4'($urandom);
    bus.cmd_cnt   = 4'($urandom);
    got_cyc = -1;
    for (int k = 1; k <= lat + 4; k++) begin
      if (k == 1) begin
        check("sel_c1", bus.sel, (op == 3) ? 0 : 3);
        if (op != 3) check("m_c1", bus.M, data);
      end else if (k <= lat - 1) begin
        check("sel_rot", bus.sel, (op == 1) ? 1 : 2);
      end
      if (bus.done) begin
        got_cyc = k;
        break;
      end
      if (busy_poke && k == 2 && lat >= 4) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    check("done_cycle", got_cyc, lat);
    check("result", bus.result, exp_res);
    check("err", bus.err, exp_err);
    check("sel_done", bus.sel, 0);
    ref_val = true_val;
    step();
    check("ready_after", bus.cmd_ready, 1);
    check("done_after", bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_done;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'hA;
    bus.cmd_cnt   = 4'h3;
    clr = 1'b1;
    step();
    step();
    check("rst_sel", bus.sel, 0);
    check("rst_m", bus.M, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    clr = 1'b0;
    bus.cmd_valid = 1'b0;
    step();
    check("post_rst_sel", bus.sel, 0);
    check("post_rst_ready", bus.cmd_ready, 1);
    ref_val = 0;

    run_cmd(0, 4'b1011, 0, 1'b0);
    run_cmd(1, 4'b0001, 1, 1'b0);
    run_cmd(2, 4'b1001, 3, 1'b0);
    run_cmd(2, 4'b0110, 15, 1'b1);
    run_cmd(3, 0, 0, 1'b0);
    run_cmd(1, 4'b1100, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom));
    end

    // Abort: clr lands in the second ROT cycle.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_data  = 4'b0101;
    bus.cmd_cnt   = 4'd10;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_sel", bus.sel, 0);
    check("abort_m", bus.M, 0);
    check("abort_result", bus.result, 0);
    any_done = 0;
    for (int k = 0; k < 14; k++) begin
      if (bus.done) any_done = 1;
      step();
    end
    check("abort_no_done", any_done, 0);
    ref_val = 0;

    mask = 4'b1011;
    run_cmd(1, 4'b1111, 2, 1'b0);
    run_cmd(3, 0, 0, 1'b0);
    mask = 4'hF;
    run_cmd(0, 4'b0110, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
